rgb_frame_writer: RTL and testbench

//  Consumes the per-pixel B/G/R stream from the Ethernet RGB24 UDP parser and places each pixel in a frame.
//  - Tracks frame geometry (x/y as one linear pixel index).
//  - Packs each pixel into a 32-bit word and tags it with a frame-buffer address.
//  - Buffers words in a small FIFO feeding the memory-write port (valid/ready), because the parser cannot be stalled.

---
 rtl/rgb_frame_writer.sv | 171 +++++++++++++++++
 tb/tb_rgb_frame_writer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/rgb_frame_writer.sv
// rgb_frame_writer
//   Takes the per-pixel B/G/R stream from the RGB24 UDP parser and places
//   each pixel in a frame. The block tracks the frame position as one linear
//   pixel index and packs each pixel into a 32-bit word {8'h00, R, G, B}.
//   It tags each word with a frame-buffer word address and queues it in a
//   small first-word-fall-through FIFO. The FIFO drives a valid/ready
//   memory-write port. The parser cannot be stalled, so the block drops a
//   pixel when the FIFO is full and records the drop in a sticky flag.
//
// Ports
//   i_clk, i_rst_n   clock; asynchronous active-low reset
//   i_valid          one-cycle strobe, i_channel_B/G/R hold one pixel
//   i_channel_B/G/R  8-bit colour channels
//   i_frame_start    pulse: the next or coincident pixel is pixel (0,0)
//   o_wr_valid       FIFO head holds a word
//   i_wr_ready       writer accepts the head word this cycle
//   o_wr_addr        BASE_ADDR + pixel index, truncated to ADDR_W
//   o_wr_data        {8'h00, R, G, B}
//   o_frame_done     pulse in the cycle after the last pixel of a frame
//   o_overflow       sticky drop flag, cleared by reset or i_frame_start
//   o_fifo_level     current FIFO occupancy

module rgb_frame_writer #(
    parameter int IMG_W      = 640,
    parameter int IMG_H      = 480,
    parameter int BASE_ADDR  = 0,
    parameter int ADDR_W     = 25,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_valid,
    input  logic [7:0]                    i_channel_B,
    input  logic [7:0]                    i_channel_G,
    input  logic [7:0]                    i_channel_R,
    input  logic                          i_frame_start,
    output logic                          o_wr_valid,
    input  logic                          i_wr_ready,
    output logic [ADDR_W-1:0]             o_wr_addr,
    output logic [31:0]                   o_wr_data,
    output logic                          o_frame_done,
    output logic                          o_overflow,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);

    localparam int TOTAL = IMG_W * IMG_H;
    localparam int IDX_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(TOTAL - 1);
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [LVL_W-1:0]  FULL_LVL = LVL_W'(FIFO_DEPTH);

    typedef enum logic [0:0] {
        S_WAIT_SYNC = 1'b0,
        S_STREAM    = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic [IDX_W-1:0] pix_idx;
    logic             take;
    logic             last_pix;

    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [LVL_W-1:0] level;
    logic             full, push, pop, drop;

    // ------------------------------------------------------------------
    // Frame geometry FSM
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= S_WAIT_SYNC;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        // A frame_start forces the coincident pixel to index 0, whichever
        // state the FSM is in.
        pix_idx   = i_frame_start ? '0 : idx;
        take      = i_valid && (state == S_STREAM || i_frame_start);
        last_pix  = take && (pix_idx == LAST_IDX);

        if (take) begin
            // The index advances even when the FIFO drops the pixel, so the
            // frame geometry is kept.
            if (last_pix) begin
                idx_nxt   = '0;
                state_nxt = S_WAIT_SYNC;
            end else begin
                idx_nxt   = pix_idx + IDX_W'(1);
                state_nxt = S_STREAM;
            end
        end else if (i_frame_start) begin
            idx_nxt   = '0;
            state_nxt = S_STREAM;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_frame_done <= 1'b0;
            o_overflow   <= 1'b0;
        end else begin
            // The pulse fires even if the last pixel itself was dropped.
            o_frame_done <= last_pix;
            // A drop in the same cycle as a frame_start belongs to the new
            // frame, so the set wins over the clear.
            if (drop)
                o_overflow <= 1'b1;
            else if (i_frame_start)
                o_overflow <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // FWFT FIFO. Fullness is judged on the level at the start of the
    // cycle, so a push into a full FIFO is dropped even when a pop
    // happens in the same cycle.
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] addr_mem [FIFO_DEPTH];
    logic [23:0]       pix_mem  [FIFO_DEPTH];

    assign full = (level == FULL_LVL);
    assign push = take && !full;
    assign drop = take && full;
    assign pop  = o_wr_valid && i_wr_ready;

    always_ff @(posedge i_clk) begin
        if (push) begin
            addr_mem[wr_ptr] <= BASE + ADDR_W'(pix_idx);
            pix_mem[wr_ptr]  <= {i_channel_R, i_channel_G, i_channel_B};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            // The depth is a power of two, so the pointers wrap naturally.
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // The head is gated with valid so that the outputs read zero while the
    // FIFO is empty. This includes reset, when the storage itself is not
    // cleared.
    assign o_wr_valid   = (level != '0);
    assign o_wr_addr    = o_wr_valid ? addr_mem[rd_ptr] : '0;
    assign o_wr_data    = o_wr_valid ? {8'h00, pix_mem[rd_ptr]} : 32'h0;
    assign o_fifo_level = level;

endmodule

// File: tb/tb_rgb_frame_writer.sv
// tb_rgb_frame_writer
//   Scoreboard bench for rgb_frame_writer on a small 4x2 frame with a
//   4-entry FIFO. An independent model predicts which pixels get accepted
//   and queues the expected {addr, data} words. Each cycle the bench checks
//   the DUT head against the front of that queue, and pops the queue
//   whenever the writer accepts a word.

module tb_rgb_frame_writer;

    localparam int IMG_W  = 4;
    localparam int IMG_H  = 2;
    localparam int BASE   = 'h100;
    localparam int ADDR_W = 25;
    localparam int DEPTH  = 4;
    localparam int TOTAL  = IMG_W * IMG_H;

    logic              i_clk = 1'b0;
    logic              i_rst_n = 1'b0;
    logic              i_valid = 1'b0;
    logic [7:0]        i_channel_B = '0, i_channel_G = '0, i_channel_R = '0;
    logic              i_frame_start = 1'b0;
    logic              o_wr_valid;
    logic              i_wr_ready = 1'b0;
    logic [ADDR_W-1:0] o_wr_addr;
    logic [31:0]       o_wr_data;
    logic              o_frame_done;
    logic              o_overflow;
    logic [$clog2(DEPTH):0] o_fifo_level;

    rgb_frame_writer #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .BASE_ADDR(BASE),
        .ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid),
        .i_channel_B(i_channel_B), .i_channel_G(i_channel_G),
        .i_channel_R(i_channel_R), .i_frame_start(i_frame_start),
        .o_wr_valid(o_wr_valid), .i_wr_ready(i_wr_ready),
        .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
        .o_frame_done(o_frame_done), .o_overflow(o_overflow),
        .o_fifo_level(o_fifo_level)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [31:0]       d;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    bit   m_stream = 0;
    int   m_idx = 0;
    bit   m_done = 0;
    bit   m_ovf = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge. The task checks the outputs of the last posedge,
    // advances the model with this cycle's stimulus, drives the stimulus and
    // then moves on to the next negedge.
    task automatic step(input bit v, input bit fs, input logic [7:0] r,
                        input logic [7:0] g, input logic [7:0] b, input bit rdy);
        bit   tk, full, pop;
        int   pidx;
        exp_t e;
        chk("valid", o_wr_valid, sb.size() != 0);
        chk("level", o_fifo_level, sb.size());
        chk("done", o_frame_done, m_done);
        chk("ovf", o_overflow, m_ovf);
        if (sb.size() != 0) begin
            chk("addr", o_wr_addr, sb[0].a);
            chk("data", o_wr_data, sb[0].d);
        end
        full = (sb.size() == DEPTH);
        pop  = (sb.size() != 0) && rdy;
        tk   = v && (m_stream || fs);
        pidx = fs ? 0 : m_idx;
        if (pop) void'(sb.pop_front());
        if (tk && !full) begin
            e.a = ADDR_W'(BASE + pidx);
            e.d = {8'h00, r, g, b};
            sb.push_back(e);
        end
        if (tk && full) m_ovf = 1;
        else if (fs) m_ovf = 0;
        m_done = tk && (pidx == TOTAL - 1);
        if (tk) begin
            if (pidx == TOTAL - 1) begin
                m_idx = 0;
                m_stream = 0;
            end else begin
                m_idx = pidx + 1;
                m_stream = 1;
            end
        end else if (fs) begin
            m_idx = 0;
            m_stream = 1;
        end
        i_valid = v; i_frame_start = fs;
        i_channel_R = r; i_channel_G = g; i_channel_B = b;
        i_wr_ready = rdy;
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    task automatic do_reset();
        i_rst_n = 0;
        i_valid = 0; i_frame_start = 0; i_wr_ready = 0;
        sb.delete();
        m_stream = 0; m_idx = 0; m_done = 0; m_ovf = 0;
        #1;
        chk("rst_valid", o_wr_valid, 0);
        chk("rst_addr", o_wr_addr, 0);
        chk("rst_data", o_wr_data, 0);
        chk("rst_done", o_frame_done, 0);
        chk("rst_ovf", o_overflow, 0);
        chk("rst_level", o_fifo_level, 0);
        @(posedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1;
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && sb.size() != 0; i++)
            step(0, 0, 0, 0, 0, 1);
        chk("drain_empty", sb.size(), 0);
        step(0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        @(negedge i_clk);
        do_reset();

        // T1: pixels before any frame_start are discarded
        for (int i = 0; i < 5; i++) step(1, 0, 8'(i), 8'h55, 8'hAA, 1);
        chk("t1_valid", o_wr_valid, 0);
        chk("t1_level", o_fifo_level, 0);

        // T2: one full frame with the writer always ready
        for (int i = 0; i < TOTAL; i++)
            step(1, i == 0, 8'(i), 8'(8'h10 + i), 8'(8'h20 + i), 1);
        chk("t2_done", o_frame_done, 1);
        drain();

        // T5: after frame_done, pixels without frame_start are ignored
        for (int i = 0; i < 3; i++) step(1, 0, 8'h77, 8'h66, 8'h55, 1);
        chk("t5_level", o_fifo_level, 0);

        // T3: overflow with the writer stalled
        for (int i = 0; i < 6; i++) step(1, i == 0, 8'(i), 8'(i + 1), 8'(i + 2), 0);
        chk("t3_level", o_fifo_level, 4);
        chk("t3_ovf", o_overflow, 1);
        drain();

        // T4: frame_start in the middle of a frame restarts at index 0
        for (int i = 0; i < 3; i++) step(1, i == 0, 8'h30, 8'(i), 8'h31, 1);
        step(1, 1, 8'hA0, 8'hA1, 8'hA2, 1);
        chk("t4_ovf", o_overflow, 0);
        chk("t4_addr", o_wr_addr, BASE);
        chk("t4_data", o_wr_data, 32'h00A0A1A2);
        step(1, 0, 8'hB0, 8'hB1, 8'hB2, 1);
        step(1, 0, 8'hC0, 8'hC1, 8'hC2, 1);
        drain();

        // T6: random backpressure and sparse input over two frames
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 40; i++)
                step(i == 0 || $urandom_range(0, 2) == 0, i == 0,
                     8'($urandom), 8'($urandom), 8'($urandom),
                     $urandom_range(0, 1) == 1);
            drain();
        end

        // Reset in the middle of operation throws away the queued words
        for (int i = 0; i < 3; i++) step(1, i == 0, 8'h11, 8'h22, 8'(i), 0);
        chk("mid_level", o_fifo_level, 3);
        do_reset();
        step(0, 0, 0, 0, 0, 1);
        step(1, 0, 8'h01, 8'h02, 8'h03, 1);
        step(0, 0, 0, 0, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
